// File: rtl/instr_mem.sv
// Instruction memory: 32 x 32-bit RV32I words, combinational read with decoded register fields,
// synchronous write port, async reset to the built-in program. Option: INSTR_MEM_ALIGN_CHECK_EN.
module instr_mem #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] readAdrs,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAdrs,
    input  logic [DATA_WIDTH-1:0] wrData
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    ,
    output logic                  misaligned
`endif
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic                  wr_ok;

    function automatic logic [DATA_WIDTH-1:0] default_word(input int unsigned idx);
        case (idx)
            0:       default_word = 32'h0050_0093;
            1:       default_word = 32'h00A0_0113;
            2:       default_word = 32'h0020_81B3;
            3:       default_word = 32'h4011_0233;
            4:       default_word = 32'h0041_A2A3;
            default: default_word = 32'h0000_0013;
        endcase
    endfunction

`ifdef INSTR_MEM_ALIGN_CHECK_EN
    assign misaligned = readAdrs[1] | readAdrs[0];
    assign wr_ok      = wrEn && (wrAdrs[1:0] == 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^{readAdrs[1:0], wrAdrs[1:0]};
    assign wr_ok           = wrEn;
`endif

    // Reset rewrites the whole array so written programs never survive a reset pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= default_word(i);
            end
        end else if (wr_ok) begin
            mem[wrAdrs[ADDR_WIDTH-1:2]] <= wrData;
        end
    end

    assign instr = mem[readAdrs[ADDR_WIDTH-1:2]];
    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed steps then randomized traffic against an array model.
module tb_instr_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  readAdrs;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic        wrEn;
    logic [6:0]  wrAdrs;
    logic [31:0] wrData;
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];
    logic [31:0] boot  [5] = '{32'h00500093, 32'h00A00113, 32'h002081B3,
                               32'h40110233, 32'h0041A2A3};

    instr_mem dut (
        .clk      (clk),
        .rst      (rst),
        .readAdrs (readAdrs),
        .instr    (instr),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .wrEn     (wrEn),
        .wrAdrs   (wrAdrs),
        .wrData   (wrData)
`ifdef INSTR_MEM_ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i < 5) ? boot[i] : 32'h00000013;
    endtask

    // Compare all read outputs against the model word the byte address selects.
    task automatic check_read(input string tag);
        logic [31:0] w;
        w = model[int'(readAdrs) / 4];
        chk({tag, ".instr"}, instr, w);
        chk({tag, ".rd"},  {27'd0, rd},  (w >> 7)  % 32);
        chk({tag, ".rs1"}, {27'd0, rs1}, (w >> 15) % 32);
        chk({tag, ".rs2"}, {27'd0, rs2}, (w >> 20) % 32);
`ifdef INSTR_MEM_ALIGN_CHECK_EN
        chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, (int'(readAdrs) % 4) != 0});
`endif
    endtask

    task automatic model_write(input logic [6:0] a, input logic [31:0] d);
`ifdef INSTR_MEM_ALIGN_CHECK_EN
        if (int'(a) % 4 != 0) return;
`endif
        model[int'(a) / 4] = d;
    endtask

    initial begin
        rst = 1'b1; wrEn = 1'b0; wrAdrs = '0; wrData = '0; readAdrs = '0;
        model_reset();
        #2;
        check_read("in_reset_addr0");
        chk("in_reset_instr0_const", instr, 32'h00500093);
        #8 rst = 1'b0;

        // Default image sweep, with spec constants checked independently of the model.
        for (int a = 0; a < 128; a += 4) begin
            readAdrs = 7'(a);
            #1;
            check_read("sweep");
        end
        readAdrs = 7'd8;  #1;
        chk("addr8_rd", {27'd0, rd}, 32'd3);
        chk("addr8_rs2", {27'd0, rs2}, 32'd2);
        readAdrs = 7'd16; #1;
        chk("addr16_instr", instr, 32'h0041A2A3);
        readAdrs = 7'd9;  #1; check_read("addr9");
        chk("addr9_instr", instr, 32'h002081B3);
        readAdrs = 7'd11; #1; check_read("addr11");

        // Write add x10,x11,x12 at byte 40.
        @(negedge clk);
        wrEn = 1'b1; wrAdrs = 7'd40; wrData = 32'h00C58533; readAdrs = 7'd40;
        #1 chk("wr40_before_edge", instr, 32'h00000013);
        @(posedge clk); model_write(7'd40, 32'h00C58533);
        #1;
        check_read("wr40_after");
        chk("wr40_rd", {27'd0, rd}, 32'd10);
        chk("wr40_rs1", {27'd0, rs1}, 32'd11);
        chk("wr40_rs2", {27'd0, rs2}, 32'd12);

        // Write while reset is held is discarded.
        @(negedge clk);
        rst = 1'b1; wrAdrs = 7'd0; wrData = 32'hDEADBEEF; readAdrs = 7'd0;
        model_reset();
        @(posedge clk); #1;
        chk("wr_in_reset", instr, 32'h00500093);
        @(negedge clk) rst = 1'b0;
        wrData = 32'hFFFFFFFF;
        @(posedge clk); model_write(7'd0, 32'hFFFFFFFF);
        #1 chk("first_wr_after_reset", instr, 32'hFFFFFFFF);
        @(negedge clk) wrEn = 1'b0;
        readAdrs = 7'd40; #1 check_read("reset_cleared40");
        readAdrs = 7'd0;
        #1 rst = 1'b1;
        model_reset();
        #1 chk("async_reset_word0", instr, 32'h00500093);
        rst = 1'b0;
        #1 check_read("after_async_reset");

`ifdef INSTR_MEM_ALIGN_CHECK_EN
        @(negedge clk);
        wrEn = 1'b1; wrAdrs = 7'd6; wrData = 32'h12345678; readAdrs = 7'd4;
        @(posedge clk); model_write(7'd6, 32'h12345678);
        #1 chk("misaligned_wr_dropped", instr, 32'h00A00113);
        @(negedge clk) wrEn = 1'b0;
`endif

        // Randomized traffic with occasional asynchronous reset pulses between edges.
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            wrEn     = ($urandom_range(2) != 0);
            wrAdrs   = 7'($urandom_range(127));
            wrData   = $urandom;
            readAdrs = ($urandom_range(1) == 0) ? wrAdrs : 7'($urandom_range(127));
            #1 check_read("rnd_pre");
            if ($urandom_range(24) == 0) begin
                rst = 1'b1;
                model_reset();
                #1 check_read("rnd_rst");
                rst = 1'b0;
            end
            @(posedge clk);
            if (wrEn) model_write(wrAdrs, wrData);
            #1 check_read("rnd_post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
